// File: rtl/exp_acc_pkg.sv
// Shared types and widths for the exponential-engine job scheduler.
package exp_acc_pkg;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned V_W        = 5;
  localparam int unsigned U_W        = 2;
  localparam int unsigned JOB_W      = V_W + U_W;
  localparam int unsigned ENG_X_W    = 16;
  localparam int unsigned RESULT_W   = 18;
  localparam int unsigned WR_DATA_W  = 21;
  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4
  } sched_state_t;

  // Zero-extend the engine result to the write width, then shift left by u.
  // Bits shifted past the top are discarded.
  function automatic logic [WR_DATA_W-1:0] shift_result(
    input logic [RESULT_W-1:0] res,
    input logic [U_W-1:0]      sh
  );
    logic [WR_DATA_W-1:0] w_ext;
    w_ext = WR_DATA_W'(res);
    return w_ext << sh;
  endfunction

endpackage

// File: rtl/job_fifo.sv
// Synchronous first-word-fall-through FIFO; o_dout shows the head entry.
// A push while full is accepted only when a pop happens in the same cycle.
module job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/exp_job_scheduler.sv
// Job scheduler feeding an exponential engine: buffers {v,u} jobs, starts the
// engine per job, and writes the shifted result through a req/ack port.
// Optional feature: define EXP_SCHED_TIMEOUT_EN to bound the engine wait and
// expose a sticky timeoutErr output.
module exp_job_scheduler
  import exp_acc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  output logic        inReady,
  input  logic [4:0]  v,
  input  logic [1:0]  u,
  output logic        engStart,
  output logic [15:0] engX,
  input  logic        engDone,
  input  logic [17:0] engResult,
  output logic        wrReq,
  input  logic        wrAck,
  output logic [20:0] wrData,
  output logic        busy
`ifdef EXP_SCHED_TIMEOUT_EN
  ,
  output logic        timeoutErr
`endif
);

  sched_state_t r_state;
  sched_state_t w_next_state;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [JOB_W-1:0]     w_head;

  logic [V_W-1:0]       r_v;
  logic [U_W-1:0]       r_u;
  logic [WR_DATA_W-1:0] r_wrdata;

`ifdef EXP_SCHED_TIMEOUT_EN
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_timeout;
`endif

  assign inReady = !rst && !w_full;
  assign w_push  = inValid && inReady;

  job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (JOB_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({v, u}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and FIFO pop strobe.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_pop        = 1'b1;
        w_next_state = ST_START;
      end
      ST_START: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (engDone) begin
          w_next_state = ST_WRITE;
        end
`ifdef EXP_SCHED_TIMEOUT_EN
        else if (r_wait_cnt == '1) begin
          w_next_state = ST_IDLE;
        end
`endif
      end
      ST_WRITE: begin
        if (wrAck) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Job registers: the head is peeked on the IDLE->LOAD edge (FIFO is
  // first-word-fall-through) so engX is already valid throughout LOAD; the
  // pop itself happens in LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      r_u <= '0;
    end else if (r_state == ST_IDLE && !w_empty) begin
      {r_v, r_u} <= w_head;
    end
  end

  // Capture and shift the engine result when it arrives during WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrdata <= '0;
    end else if (r_state == ST_WAIT && engDone) begin
      r_wrdata <= shift_result(engResult, r_u);
    end
  end

`ifdef EXP_SCHED_TIMEOUT_EN
  // WAIT-cycle counter, preloaded to 1 so it equals the current WAIT cycle
  // number; the sticky error flags a job dropped at count 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == ST_START) begin
        r_wait_cnt <= WAIT_CNT_W'(1);
      end else if (r_state == ST_WAIT && !engDone && r_wait_cnt != '1) begin
        r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
      end
      if (r_state == ST_WAIT && !engDone && r_wait_cnt == '1) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeoutErr = r_timeout;
`endif

  assign engStart = (r_state == ST_START);
  assign engX     = {3'b000, r_v, 8'b0000_0000};
  assign wrReq    = (r_state == ST_WRITE);
  assign wrData   = r_wrdata;
  assign busy     = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_exp_job_scheduler.sv
// Self-checking bench for exp_job_scheduler with a scoreboard of expected
// write data and a behavioural engine model driven from the same process.
module tb_exp_job_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [4:0]  v;
  logic [1:0]  u;
  logic        engStart;
  logic [15:0] engX;
  logic        engDone;
  logic [17:0] engResult;
  logic        wrReq;
  logic        wrAck;
  logic [20:0] wrData;
  logic        busy;
`ifdef EXP_SCHED_TIMEOUT_EN
  logic        timeoutErr;
`endif

  exp_job_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .inValid   (inValid),
    .inReady   (inReady),
    .v         (v),
    .u         (u),
    .engStart  (engStart),
    .engX      (engX),
    .engDone   (engDone),
    .engResult (engResult),
    .wrReq     (wrReq),
    .wrAck     (wrAck),
    .wrData    (wrData),
    .busy      (busy)
`ifdef EXP_SCHED_TIMEOUT_EN
    ,
    .timeoutErr(timeoutErr)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [20:0] exp_q [$];
  logic [17:0] res_q [$];
  logic [4:0]  vq    [$];

  bit          eng_en;
  int          eng_lat;
  bit          eng_pending;
  int          eng_cnt;
  logic [17:0] cur_res;
  bit          ack_en;
  int          ack_dly;
  int          req_age;
  logic [20:0] held;
  int          writes;

  function automatic logic [20:0] model(input logic [17:0] r, input logic [1:0] s);
    logic [20:0] t;
    t = {3'b000, r};
    return t << s;
  endfunction

  // One clock: advance past the edge, then act as engine and write target.
  task automatic cycle();
    logic [4:0]  ev;
    logic [20:0] e;
    @(posedge clk);
    #1;
    engDone = 1'b0;
    if (eng_pending) begin
      if (eng_cnt <= 1) begin
        engDone     = 1'b1;
        engResult   = cur_res;
        eng_pending = 1'b0;
      end else begin
        eng_cnt--;
      end
    end
    if (engStart === 1'b1 && eng_en) begin
      vectors++;
      if (res_q.size() == 0) begin
        miscompares++;
        $display("FAIL engStart_spurious: engStart=1 with no job outstanding");
      end else begin
        cur_res     = res_q.pop_front();
        ev          = vq.pop_front();
        eng_pending = 1'b1;
        eng_cnt     = eng_lat;
        if (engX !== {3'b000, ev, 8'h00}) begin
          miscompares++;
          $display("FAIL engX: got %h expected %h", engX, {3'b000, ev, 8'h00});
        end
      end
    end
    wrAck = 1'b0;
    if (wrReq === 1'b1) begin
      if (req_age == 0) begin
        held = wrData;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL wrReq_spurious: wrReq=1 data %h with nothing expected", wrData);
        end
      end else begin
        vectors++;
        if (wrData !== held) begin
          miscompares++;
          $display("FAIL wrData_stable: got %h held %h", wrData, held);
        end
      end
      req_age++;
      if (ack_en && req_age > ack_dly && exp_q.size() != 0) begin
        wrAck = 1'b1;
        e     = exp_q.pop_front();
        writes++;
        vectors++;
        if (wrData !== e) begin
          miscompares++;
          $display("FAIL wrData: got %h expected %h", wrData, e);
        end
      end
    end else begin
      req_age = 0;
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    res_q.delete();
    vq.delete();
    eng_pending = 1'b0;
    req_age     = 0;
    writes      = 0;
    engDone     = 1'b0;
  endtask

  task automatic reset_pulse();
    rst     = 1'b1;
    inValid = 1'b0;
    cycle();
    rst = 1'b0;
    clear_model();
    #1;
  endtask

  task automatic offer(input logic [4:0] jv, input logic [1:0] ju, input logic [17:0] jres,
                       input logic [20:0] jexp, input int max_cycles, output bit ok);
    inValid = 1'b1;
    v       = jv;
    u       = ju;
    ok      = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      if (inReady === 1'b1) begin
        ok = 1'b1;
        exp_q.push_back(jexp);
        res_q.push_back(jres);
        vq.push_back(jv);
      end
      cycle();
    end
    inValid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && (busy !== 1'b0 || exp_q.size() != 0); i++) begin
      cycle();
    end
    vectors++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: busy=%b pending=%0d after %0d cycles", busy, exp_q.size(), maxc);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    inValid = 1'b1;
    v       = 5'd7;
    u       = 2'd1;
    wrAck   = 1'b0;
    engDone = 1'b0;
    engResult = '0;
    cycle();
    cycle();
    vectors += 6;
    if (inReady !== 1'b0) begin miscompares++; $display("FAIL rst_inReady: got %b expected 0", inReady); end
    if (engStart !== 1'b0) begin miscompares++; $display("FAIL rst_engStart: got %b expected 0", engStart); end
    if (wrReq !== 1'b0) begin miscompares++; $display("FAIL rst_wrReq: got %b expected 0", wrReq); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (engX !== 16'h0000) begin miscompares++; $display("FAIL rst_engX: got %h expected 0000", engX); end
    if (wrData !== 21'h0) begin miscompares++; $display("FAIL rst_wrData: got %h expected 0", wrData); end
    inValid = 1'b0;
    rst     = 1'b0;
    clear_model();
    #1;
    vectors++;
    if (inReady !== 1'b1) begin miscompares++; $display("FAIL post_rst_inReady: got %b expected 1", inReady); end
  endtask

  task automatic test_single();
    bit ok;
    int start_idx = -1;
    int done_idx  = -1;
    int req_idx   = -1;
    reset_pulse();
    eng_en = 1'b1; eng_lat = 3; ack_en = 1'b1; ack_dly = 2;
    offer(5'd1, 2'd0, 18'h0ABCD, 21'h00ABCD, 1, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL single_accept: got 0 expected 1"); end
    for (int idx = 1; idx < 40 && (writes == 0 || busy !== 1'b0); idx++) begin
      cycle();
      if (idx == 1) begin
        vectors++;
        if (busy !== 1'b1 || engStart !== 1'b0) begin
          miscompares++;
          $display("FAIL load_cycle: busy=%b engStart=%b expected 1/0", busy, engStart);
        end
      end
      if (engStart === 1'b1 && start_idx < 0) start_idx = idx;
      if (engDone === 1'b1 && done_idx < 0) done_idx = idx;
      if (wrReq === 1'b1 && req_idx < 0) req_idx = idx;
    end
    vectors += 3;
    if (start_idx != 2) begin miscompares++; $display("FAIL engStart_cycle: got %0d expected 2", start_idx); end
    if (done_idx < 0 || req_idx != done_idx + 1) begin
      miscompares++; $display("FAIL wrReq_cycle: got %0d expected %0d", req_idx, done_idx + 1);
    end
    if (writes != 1) begin miscompares++; $display("FAIL single_writes: got %0d expected 1", writes); end
  endtask

  task automatic test_shift();
    bit ok;
    logic [17:0] r;
    reset_pulse();
    eng_en = 1'b1; eng_lat = 2; ack_en = 1'b1; ack_dly = 0;
    offer(5'd3, 2'd3, 18'h3FFFF, 21'h1FFFF8, 4, ok);
    drain(40);
    offer(5'd31, 2'd2, 18'h2AAAA, 21'h0AAAA8, 4, ok);
    drain(40);
    for (int i = 0; i < 4; i++) begin
      r = 18'($urandom);
      offer(5'($urandom), 2'(i), r, model(r, 2'(i)), 4, ok);
    end
    drain(200);
    vectors++;
    if (writes != 6) begin miscompares++; $display("FAIL shift_writes: got %0d expected 6", writes); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [17:0] r;
    reset_pulse();
    eng_en = 1'b1; eng_lat = 2; ack_en = 1'b0; ack_dly = 0;
    for (int i = 0; i < 5; i++) begin
      r = 18'h01357 * 18'(i + 1);
      offer(5'(i + 2), 2'(i), r, model(r, 2'(i)), 1, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL b2b_accept%0d: got 0 expected 1", i); end
    end
    offer(5'd20, 2'd1, 18'h1F00F, model(18'h1F00F, 2'd1), 4, ok);
    vectors += 2;
    if (ok) begin miscompares++; $display("FAIL b2b_full_accept: got 1 expected 0"); end
    if (inReady !== 1'b0) begin miscompares++; $display("FAIL b2b_inReady: got %b expected 0", inReady); end
    ack_en = 1'b1;
    offer(5'd20, 2'd1, 18'h1F00F, model(18'h1F00F, 2'd1), 60, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_late_accept: got 0 expected 1"); end
    drain(300);
    vectors++;
    if (writes != 6) begin miscompares++; $display("FAIL b2b_writes: got %0d expected 6", writes); end
  endtask

  task automatic test_full_push_pop();
    bit ok;
    int low_cycles = 0;
    logic [17:0] r;
    reset_pulse();
    eng_en = 1'b1; eng_lat = 1; ack_en = 1'b0; ack_dly = 0;
    for (int i = 0; i < 5; i++) begin
      r = 18'h2468A ^ 18'(i * 18'h111);
      offer(5'(9 + i), 2'(3 - i % 4), r, model(r, 2'(3 - i % 4)), 1, ok);
    end
    for (int i = 0; i < 20 && wrReq !== 1'b1; i++) cycle();
    vectors++;
    if (wrReq !== 1'b1 || inReady !== 1'b0) begin
      miscompares++; $display("FAIL fpp_full: wrReq=%b inReady=%b expected 1/0", wrReq, inReady);
    end
    ack_en  = 1'b1;
    inValid = 1'b1;
    v       = 5'd30;
    u       = 2'd2;
    ok      = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (inReady === 1'b1) begin
        ok = 1'b1;
        exp_q.push_back(model(18'h15555, 2'd2));
        res_q.push_back(18'h15555);
        vq.push_back(5'd30);
      end else begin
        low_cycles++;
      end
      cycle();
    end
    inValid = 1'b0;
    vectors += 2;
    if (!ok || low_cycles == 0) begin
      miscompares++; $display("FAIL fpp_accept: ok=%b low_cycles=%0d expected 1/>0", ok, low_cycles);
    end
    if (inReady !== 1'b0) begin miscompares++; $display("FAIL fpp_refull: inReady=%b expected 0", inReady); end
    drain(300);
    vectors++;
    if (writes != 6) begin miscompares++; $display("FAIL fpp_writes: got %0d expected 6", writes); end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    reset_pulse();
    eng_en = 1'b0; ack_en = 1'b1; ack_dly = 0;
    offer(5'd5, 2'd1, 18'h00100, 21'h0, 1, ok);
    offer(5'd6, 2'd2, 18'h00200, 21'h0, 1, ok);
    for (int i = 0; i < 10 && engStart !== 1'b1; i++) cycle();
    cycle();
    cycle();
    reset_pulse();
    engDone   = 1'b1;
    engResult = 18'h3FFFF;
    for (int i = 0; i < 6; i++) begin
      cycle();
      vectors++;
      if (wrReq !== 1'b0 || busy !== 1'b0 || inReady !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_wait_idle: wrReq=%b busy=%b inReady=%b expected 0/0/1", wrReq, busy, inReady);
      end
    end
  endtask

`ifdef EXP_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int idx = 0;
    reset_pulse();
    eng_en = 1'b0; ack_en = 1'b1; ack_dly = 0;
    offer(5'd4, 2'd0, 18'h00001, 21'h0, 1, ok);
    exp_q.delete(); res_q.delete(); vq.delete();
    for (int i = 0; i < 10 && engStart !== 1'b1; i++) cycle();
    vectors++;
    if (timeoutErr !== 1'b0) begin miscompares++; $display("FAIL to_early: timeoutErr=%b expected 0", timeoutErr); end
    while (idx < 400 && busy !== 1'b0) begin
      cycle();
      idx++;
    end
    vectors += 2;
    if (idx != 256) begin miscompares++; $display("FAIL to_cycles: got %0d expected 256", idx); end
    if (timeoutErr !== 1'b1) begin miscompares++; $display("FAIL to_flag: got %b expected 1", timeoutErr); end
    eng_en = 1'b1; eng_lat = 2;
    offer(5'd8, 2'd1, 18'h12345, model(18'h12345, 2'd1), 4, ok);
    drain(60);
    vectors++;
    if (writes != 1 || timeoutErr !== 1'b1) begin
      miscompares++; $display("FAIL to_next: writes=%0d timeoutErr=%b expected 1/1", writes, timeoutErr);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; inValid = 1'b0; v = '0; u = '0;
    engDone = 1'b0; engResult = '0; wrAck = 1'b0;
    eng_en = 1'b0; eng_lat = 1; ack_en = 1'b0; ack_dly = 0;
    clear_model();
    test_reset();
    test_single();
    test_shift();
    test_back_to_back();
    test_full_push_pop();
    test_reset_in_wait();
`ifdef EXP_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
